gfb_cmd_engine: RTL

GFB_CMD_ENGINE -- requirements
Module: gfb_cmd_engine

---
 rtl/gfb_cmd_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gfb_cmd_engine.sv
// gfb_cmd_engine
//   Queued command engine in front of an internal 2^AW x DW word store.
//   Commands are pushed into a DEPTH-entry FIFO and executed one at a time
//   by a counter-driven FSM: READ, WRITE, ROW_WRITE, ERASE, MASS_ERASE, and
//   an error completion for unknown codes. ABORT flushes the queue and
//   terminates the active operation with an error completion.
//
// Ports
//   SCLK          clock
//   RESET_sclk    synchronous active-high reset (control state only)
//   CMD_VALID     command offer
//   CMD           command code (0 IDLE/ignored, 1..5 ops, 6/7 error)
//   ADDR          word address
//   WDATA         write data
//   ABORT         flush queue and terminate active op
//   READY_sclk    command accept (queue not full and no ABORT)
//   RDATA_sclk    data of the last completed READ
//   RESP_sclk     1 = error/aborted, qualified by DONE_sclk
//   DONE_sclk     one-cycle completion pulse
//   BUSY_sclk     engine not idle
//   QLEVEL_sclk   queue occupancy
module gfb_cmd_engine #(
    parameter int AW        = 10,
    parameter int DW        = 10,
    parameter int DEPTH     = 4,
    parameter int ROW_WORDS = 8,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 4
) (
    input  logic                     SCLK,
    input  logic                     RESET_sclk,
    input  logic                     CMD_VALID,
    input  logic [2:0]               CMD,
    input  logic [AW-1:0]            ADDR,
    input  logic [DW-1:0]            WDATA,
    input  logic                     ABORT,
    output logic                     READY_sclk,
    output logic [DW-1:0]            RDATA_sclk,
    output logic                     RESP_sclk,
    output logic                     DONE_sclk,
    output logic                     BUSY_sclk,
    output logic [$clog2(DEPTH):0]   QLEVEL_sclk
);

    localparam int PW   = $clog2(DEPTH);
    localparam int MEMW = 2 ** AW;
    localparam int M1   = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int M2   = (M1 > ROW_WORDS) ? M1 : ROW_WORDS;
    localparam int M3   = (M2 > MEMW) ? M2 : MEMW;
    localparam int CW   = $clog2(M3 + 1);
    localparam int EW   = 3 + AW + DW;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_ROWWR, S_ERASE, S_MERASE, S_ERR
    } state_t;

    logic [EW-1:0]  fifo_q [DEPTH];
    logic [PW:0]    wptr_q, rptr_q;
    logic [PW:0]    level;
    logic           full, empty, push, last;
    logic [EW-1:0]  head;
    logic [2:0]     head_cmd;
    logic [AW-1:0]  head_addr;
    logic [DW-1:0]  head_wdata;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [AW-1:0]  idx_q, addr_q;
    logic [DW-1:0]  wdata_q, rdata_q;
    logic           done_q, resp_q;

    logic [DW-1:0]  mem_q [MEMW];
    logic           mem_we;
    logic [AW-1:0]  mem_waddr, row_mask, row_addr;
    logic [DW-1:0]  mem_wdata;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level       = wptr_q - rptr_q;
    assign full        = (level == (PW+1)'(DEPTH));
    assign empty       = (level == '0);
    assign READY_sclk  = !full && !ABORT;
    assign push        = CMD_VALID && READY_sclk && (CMD != 3'd0);

    assign head        = fifo_q[rptr_q[PW-1:0]];
    assign head_cmd    = head[EW-1 -: 3];
    assign head_addr   = head[DW +: AW];
    assign head_wdata  = head[DW-1:0];

    assign last        = (cnt_q == CW'(1));

    // Row walk keeps the row bits of the address and wraps the index inside the row.
    assign row_mask    = AW'(ROW_WORDS - 1);
    assign row_addr    = (addr_q & ~row_mask) | (idx_q & row_mask);

    assign RDATA_sclk  = rdata_q;
    assign RESP_sclk   = resp_q;
    assign DONE_sclk   = done_q;
    assign BUSY_sclk   = (state_q != S_IDLE);
    assign QLEVEL_sclk = level;

    // Storage write port; ABORT and reset both suppress the write of that edge.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        if (!RESET_sclk && !ABORT) begin
            case (state_q)
                S_WR:     mem_we = last;
                S_ROWWR:  begin mem_we = 1'b1; mem_waddr = row_addr; end
                S_ERASE:  begin mem_we = 1'b1; mem_waddr = row_addr; mem_wdata = '1; end
                S_MERASE: begin mem_we = 1'b1; mem_waddr = idx_q;    mem_wdata = '1; end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge SCLK) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge SCLK) begin
        if (RESET_sclk) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            resp_q <= 1'b0;
            if (ABORT) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                state_q <= S_IDLE;
                if (state_q != S_IDLE) begin
                    done_q <= 1'b1;
                    resp_q <= 1'b1;
                end
            end else begin
                if (push) begin
                    fifo_q[wptr_q[PW-1:0]] <= {CMD, ADDR, WDATA};
                    wptr_q <= wptr_q + 1'b1;
                end
                if (state_q == S_IDLE) begin
                    if (!empty) begin
                        rptr_q  <= rptr_q + 1'b1;
                        addr_q  <= head_addr;
                        wdata_q <= head_wdata;
                        idx_q   <= '0;
                        case (head_cmd)
                            3'd1:    begin state_q <= S_RD;     cnt_q <= CW'(READ_LAT);  end
                            3'd2:    begin state_q <= S_WR;     cnt_q <= CW'(WRITE_LAT); end
                            3'd3:    begin state_q <= S_ROWWR;  cnt_q <= CW'(ROW_WORDS); end
                            3'd4:    begin state_q <= S_ERASE;  cnt_q <= CW'(ROW_WORDS); end
                            3'd5:    begin state_q <= S_MERASE; cnt_q <= CW'(MEMW);      end
                            default: begin state_q <= S_ERR;    cnt_q <= CW'(1);         end
                        endcase
                    end
                end else begin
                    idx_q <= idx_q + 1'b1;
                    if (last) begin
                        done_q  <= 1'b1;
                        resp_q  <= (state_q == S_ERR);
                        state_q <= S_IDLE;
                        if (state_q == S_RD) rdata_q <= mem_q[addr_q];
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            end
        end
    end

endmodule
